// File: rtl/terminal_pkg.sv
// terminal_pkg: constants shared by the terminal character writer and its
// cursor tracker.
//   - ASCII codes the writer interprets (space, BS, LF, CR, FF, printable range)
//   - default screen geometry (80 x 30)
//   - FSM state encoding of the writer (CLEAR_ALL, IDLE, CLEAR_LINE)
package terminal_pkg;

  localparam int DEF_COLS = 80;
  localparam int DEF_ROWS = 30;

  localparam logic [7:0] ASC_SPACE    = 8'h20;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_LF       = 8'h0A;
  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_FF       = 8'h0C;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

  // Writer FSM encoding. Both clear states share one datapath and differ only
  // in the address range loaded when they are entered.
  localparam logic [1:0] CLEAR_ALL  = 2'd0;
  localparam logic [1:0] IDLE       = 2'd1;
  localparam logic [1:0] CLEAR_LINE = 2'd2;

endpackage

// File: rtl/terminal_cursor.sv
// terminal_cursor: cursor position tracker for the terminal writer.
// Commands are single-cycle strobes, already qualified by byte acceptance.
// Ports:
//   iVGA_CLK, iRST_n          clock, asynchronous active-low reset
//   cmd_advance               printable byte written: step right, wrap at row end
//   cmd_back                  backspace: step left unless already at column 0
//   cmd_home                  form feed: go to (0,0)
//   cmd_newline               line feed: column 0 and advance row
//   cmd_cr                    carriage return: column 0
//   col, row                  registered cursor position
//   wrap                      the next row advance wraps from the last row to row 0
//   row_adv                   this cycle's command advances the row
//   cursor_addr               registered row*COLS+col (TERMINAL_CURSOR_EN only)
// Optional feature macro: TERMINAL_CURSOR_EN.
module terminal_cursor
  import terminal_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
`ifdef TERMINAL_CURSOR_EN
  , parameter int ADDR_W = 12
`endif
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       cmd_advance,
  input  logic       cmd_back,
  input  logic       cmd_home,
  input  logic       cmd_newline,
  input  logic       cmd_cr,
  output logic [6:0] col,
  output logic [4:0] row,
  output logic       wrap,
  output logic       row_adv
`ifdef TERMINAL_CURSOR_EN
  , output logic [ADDR_W-1:0] cursor_addr
`endif
);

  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  logic [6:0] col_nxt;
  logic [4:0] row_nxt;

  assign wrap    = (row == ROW_LAST);
  assign row_adv = cmd_newline || (cmd_advance && (col == COL_LAST));

  always_comb begin
    // NOTE: defaults first so every path assigns both signals; no latch is inferred.
    col_nxt = col;
    row_nxt = row;
    if (cmd_home) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (row_adv) begin
      col_nxt = '0;
      row_nxt = wrap ? '0 : row + 5'd1;
    end else if (cmd_cr) begin
      col_nxt = '0;
    end else if (cmd_back && (col != '0)) begin
      col_nxt = col - 7'd1;
    end else if (cmd_advance) begin
      col_nxt = col + 7'd1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (!iRST_n) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

`ifdef TERMINAL_CURSOR_EN
  // Built from the next-state position so it moves on the same edge as col/row.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) cursor_addr <= '0;
    else         cursor_addr <= ADDR_W'(int'(row_nxt) * COLS + int'(col_nxt));
  end
`endif

endmodule

// File: rtl/terminal_char_writer.sv
// terminal_char_writer: writer side of the VGA terminal character RAM.
// Consumes ASCII bytes over valid/ready, tracks the cursor, and issues one
// registered write per cycle for printable characters, backspace erase, and
// line / full-screen clears (no scrolling; rows wrap).
// Ports:
//   iVGA_CLK, iRST_n     pixel clock, asynchronous active-low reset
//   char_valid/char_data input byte; consumed when char_valid && char_ready
//   char_ready           high only in IDLE
//   wr_en/wr_addr/wr_data character RAM write port (address row*COLS+col)
//   busy                 a clear sequence is running
//   cur_col, cur_row     cursor position
//   cursor_addr, cursor_vis  cursor address and blink (TERMINAL_CURSOR_EN only)
// Optional feature macro: TERMINAL_CURSOR_EN (adds the cursor address/blink
// outputs and the BLINK_CYCLES parameter).
module terminal_char_writer
  import terminal_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = 12
`ifdef TERMINAL_CURSOR_EN
  , parameter int BLINK_CYCLES = 12500000
`endif
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  output logic              char_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic [6:0]        cur_col,
  output logic [4:0]        cur_row
`ifdef TERMINAL_CURSOR_EN
  , output logic [ADDR_W-1:0] cursor_addr
  , output logic              cursor_vis
`endif
);

  // One extra bit so the exclusive end address COLS*ROWS never aliases to 0.
  localparam int              CLR_W      = ADDR_W + 1;
  localparam logic [CLR_W-1:0] SCREEN_END = CLR_W'(COLS * ROWS);
  localparam logic [CLR_W-1:0] LINE_LEN   = CLR_W'(COLS);

  logic [1:0]        state;
  logic [CLR_W-1:0]  clr_addr;
  logic [CLR_W-1:0]  clr_end;
  logic [CLR_W-1:0]  line_base;
  logic [ADDR_W-1:0] cur_addr;
  logic accept, is_print, is_bs, is_lf, is_cr, is_ff;
  logic wrap, row_adv;

  assign accept   = char_valid && char_ready;
  assign is_print = (char_data >= ASC_PRINT_LO) && (char_data <= ASC_PRINT_HI);
  assign is_bs    = (char_data == ASC_BS);
  assign is_lf    = (char_data == ASC_LF);
  assign is_cr    = (char_data == ASC_CR);
  assign is_ff    = (char_data == ASC_FF);

  assign cur_addr  = ADDR_W'(int'(cur_row) * COLS + int'(cur_col));
  // Start of the row the cursor moves to on a row advance.
  assign line_base = wrap ? '0 : CLR_W'((int'(cur_row) + 1) * COLS);

  terminal_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
`ifdef TERMINAL_CURSOR_EN
    , .ADDR_W (ADDR_W)
`endif
  ) u_cursor (
    .iVGA_CLK    (iVGA_CLK),
    .iRST_n      (iRST_n),
    .cmd_advance (accept && is_print),
    .cmd_back    (accept && is_bs),
    .cmd_home    (accept && is_ff),
    .cmd_newline (accept && is_lf),
    .cmd_cr      (accept && is_cr),
    .col         (cur_col),
    .row         (cur_row),
    .wrap        (wrap),
    .row_adv     (row_adv)
`ifdef TERMINAL_CURSOR_EN
    , .cursor_addr (cursor_addr)
`endif
  );

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state      <= CLEAR_ALL;
      clr_addr   <= '0;
      clr_end    <= SCREEN_END;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= ASC_SPACE;
      char_ready <= 1'b0;
      busy       <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_print) begin
              wr_en   <= 1'b1;
              wr_addr <= cur_addr;
              wr_data <= char_data;
            end else if (is_bs && (cur_col != '0)) begin
              // Erase the cell the cursor steps back onto.
              wr_en   <= 1'b1;
              wr_addr <= cur_addr - ADDR_W'(1);
              wr_data <= ASC_SPACE;
            end
            if (is_ff) begin
              state      <= CLEAR_ALL;
              clr_addr   <= '0;
              clr_end    <= SCREEN_END;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end else if (row_adv) begin
              state      <= CLEAR_LINE;
              clr_addr   <= line_base;
              clr_end    <= line_base + LINE_LEN;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        CLEAR_ALL, CLEAR_LINE: begin
          // The cycle after the last space is issued hands back to IDLE, so
          // char_ready never overlaps a clear write.
          if (clr_addr == clr_end) begin
            state      <= IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end else begin
            wr_en    <= 1'b1;
            wr_addr  <= clr_addr[ADDR_W-1:0];
            wr_data  <= ASC_SPACE;
            clr_addr <= clr_addr + CLR_W'(1);
          end
        end
        default: begin
          state      <= CLEAR_ALL;
          clr_addr   <= '0;
          clr_end    <= SCREEN_END;
          char_ready <= 1'b0;
          busy       <= 1'b1;
        end
      endcase
    end
  end

`ifdef TERMINAL_CURSOR_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BLINK_W-1:0] blink_cnt;

  // Typing restarts the phase with the cursor shown.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      blink_cnt  <= '0;
      cursor_vis <= 1'b1;
    end else if (accept) begin
      blink_cnt  <= '0;
      cursor_vis <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
      blink_cnt  <= '0;
      cursor_vis <= ~cursor_vis;
    end else begin
      blink_cnt  <= blink_cnt + BLINK_W'(1);
    end
  end
`endif

endmodule
